serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the number of data bits per frame (legal 4..16).
REQ-002 Parameter PARITY_EN, default 1, SHALL add one even-parity bit after the data bits when 1 (no parity bit when 0).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 en  input  1  SHALL be the bit strobe; sin SHALL be sampled only on rising edges where en=1.
REQ-006 sin  input  1  SHALL be the serial line (idle high, LSB first).
REQ-007 data  output  DATA_WIDTH  SHALL hold the last received data word, registered.
REQ-008 valid  output  1  SHALL pulse high for one clk cycle when a good frame completes.
REQ-009 parity_err  output  1  SHALL pulse high for one clk cycle on a parity mismatch.
REQ-010 frame_err  output  1  SHALL pulse high for one clk cycle on a missing stop bit.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-012 Frame format SHALL be: start (0), DATA_WIDTH data bits LSB first, parity bit (if PARITY_EN), stop (1); one bit per en strobe.
REQ-013 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: on en=1 with sin=0 -> DATA, bit counter cleared; en=1 with sin=1 or en=0 -> stay.
REQ-015 DATA: each en=1 shifts sin into the shift register at the MSB end (right shift); after DATA_WIDTH strobes -> PARITY if PARITY_EN, else STOP.
REQ-016 Bit counter width SHALL be clog2(DATA_WIDTH+1); it SHALL never wrap within a frame.
REQ-017 PARITY: on en=1, latch sin as the received parity -> STOP; even parity means XOR(data bits, parity bit)=0.
REQ-018 STOP: on en=1 -> IDLE.
REQ-019 At that STOP edge, sin=1 with parity OK: data loaded from the shift register and valid=1 in the following cycle.
REQ-020 At that STOP edge, sin=1 with parity bad: parity_err=1; data unchanged; valid=0.
REQ-021 At that STOP edge, sin=0: frame_err=1; data unchanged; valid=0. frame_err takes priority over parity_err, and both SHALL never be high together.
REQ-022 Latency: valid/err pulse SHALL appear exactly one clk after the edge that samples the stop bit.
REQ-023 en=0 cycles mid-frame SHALL freeze all state (no timeout).
REQ-024 Any error SHALL return the FSM to IDLE; a new start bit is accepted on the next en strobe.
REQ-025 A start bit strobed on the cycle immediately after the STOP edge SHALL be accepted (back-to-back frames).

Reset
REQ-026 reset=1 at a rising edge SHALL force state=IDLE, data=0, valid=0, parity_err=0, frame_err=0, busy=0, bit counter=0, shift register=0.
REQ-027 reset SHALL take priority over en at the same edge; reset mid-frame SHALL discard the partial frame with no pulse.

Structure
REQ-028 State encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3) SHALL live in shared include file serial_frame_defs.vh, for reuse by the future serial_frame_tx.
REQ-029 The shift register SHALL be one sub-module, sipo_shift_reg (clk, reset, en, din, q[DATA_WIDTH-1:0]); FSM, counter and checks SHALL stay in the top module.

Verification
REQ-030 Reset 2 cycles, then frame 0xA5 (bits 0,1,0,1,0,0,1,0,1,p=0,1), en every cycle -> valid=1 one cycle, data=8'hA5, busy low afterwards.
REQ-031 Frame 0x3C with parity bit forced to 1 -> parity_err=1 one cycle, valid=0, data keeps its previous value 8'hA5.
REQ-032 Frame 0x0F with stop bit 0 -> frame_err=1 one cycle, parity_err=0, valid=0, FSM in IDLE.
REQ-033 Frame 0x81 with en strobing every 4th cycle -> valid exactly one cycle after the stop strobe edge, data=8'h81.
REQ-034 Assert reset after the 4th data bit of 0xFF, then send 0x55 -> no pulse from the aborted frame, then valid=1, data=8'h55.
REQ-035 Back-to-back frames 0x12 then 0x34 with no idle bit -> two valid pulses, data 8'h12 then 8'h34.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Types and helpers shared by the serial frame receiver files.
`include "serial_frame_defs.vh"

package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = `SF_ST_IDLE,
        ST_DATA   = `SF_ST_DATA,
        ST_PARITY = `SF_ST_PARITY,
        ST_STOP   = `SF_ST_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        RES_GOOD   = 2'd0,
        RES_PARITY = 2'd1,
        RES_FRAME  = 2'd2
    } rx_result_e;

    // A missing stop bit outranks a parity mismatch.
    function automatic rx_result_e classify_frame(input logic stop_bit, input logic parity_ok);
        rx_result_e res;
        if (!stop_bit) begin
            res = RES_FRAME;
        end else if (!parity_ok) begin
            res = RES_PARITY;
        end else begin
            res = RES_GOOD;
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_frame_defs.vh
// State encodings shared by the serial frame receiver and the future transmitter.
`ifndef SERIAL_FRAME_DEFS_VH
`define SERIAL_FRAME_DEFS_VH

`define SF_ST_IDLE   2'd0
`define SF_ST_DATA   2'd1
`define SF_ST_PARITY 2'd2
`define SF_ST_STOP   2'd3

`endif

// File: rtl/serial_frame_rx_sipo_shift_reg.sv
// Serial-in parallel-out shift register; new bits enter at the MSB so an
// LSB-first stream ends up in natural bit order.
module sipo_shift_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] q_q;
    logic [DATA_WIDTH-1:0] q_d;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            if (gi == DATA_WIDTH - 1) begin : g_top
                assign q_d[gi] = din;
            end else begin : g_inner
                assign q_d[gi] = q_q[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Strobed serial frame receiver: start, LSB-first data, optional even parity,
// stop. Reports good frames and parity/framing errors as one-cycle pulses.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sin,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  rx_parity_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  parity_err_q;
    logic                  frame_err_q;

    logic [DATA_WIDTH-1:0] shift_q;
    logic                  shift_en_d;
    logic                  parity_ok_d;
    rx_result_e            result_d;

    assign shift_en_d = en && (state_q == ST_DATA);

    sipo_shift_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .clk  (clk),
        .reset(reset),
        .en   (shift_en_d),
        .din  (sin),
        .q    (shift_q)
    );

    // With parity disabled every frame counts as parity-clean.
    assign parity_ok_d = !PARITY_EN || ((^shift_q ^ rx_parity_q) == 1'b0);
    assign result_d    = classify_frame(sin, parity_ok_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rx_parity_q  <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!sin) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_q <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        rx_parity_q <= sin;
                        state_q     <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        case (result_d)
                            RES_GOOD: begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
                            RES_PARITY: parity_err_q <= 1'b1;
                            default:    frame_err_q  <= 1'b1;
                        endcase
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomised and directed frames against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         sin;
    logic [W-1:0] data;
    logic         valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_data;
    int valid_seen     = 0;
    int valid_expected = 0;
    int overlap        = 0;

    always #5 clk = ~clk;

    serial_frame_rx #(
        .DATA_WIDTH(W),
        .PARITY_EN (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sin       (sin),
        .data      (data),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (valid === 1'b1) valid_seen++;
        if (parity_err === 1'b1 && frame_err === 1'b1) overlap++;
    end

    task automatic strobe(input logic b, input int gap);
        en  = 1'b1;
        sin = b;
        @(posedge clk);
        #1;
        en  = 1'b0;
        sin = 1'b1;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic flip, input logic stop_bit,
                              input int gap, input bit b2b, input string name);
        logic p;
        int   ones;
        bit   exp_v, exp_p, exp_f;
        ones  = $countones(d);
        p     = ((ones % 2) == 1) ? 1'b1 : 1'b0;
        p     = p ^ flip;
        ones  = ones + (p ? 1 : 0);
        exp_f = !stop_bit;
        exp_p = stop_bit && ((ones % 2) != 0);
        exp_v = stop_bit && ((ones % 2) == 0);

        strobe(1'b0, gap);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_mid: got %b want 1", name, busy);
        end
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse_len: valid got %b want 0", name, valid);
        end
        for (int i = 0; i < W; i++) strobe(d[i], gap);
        strobe(p, gap);

        en  = 1'b1;
        sin = stop_bit;
        @(posedge clk);
        #1;
        en  = 1'b0;
        sin = 1'b1;
        if (exp_v) begin
            model_data = d;
            valid_expected++;
        end

        total++;
        if (valid !== exp_v) begin
            bad++;
            $display("FAIL %s valid: got %b want %b", name, valid, exp_v);
        end
        total++;
        if (parity_err !== exp_p) begin
            bad++;
            $display("FAIL %s parity_err: got %b want %b", name, parity_err, exp_p);
        end
        total++;
        if (frame_err !== exp_f) begin
            bad++;
            $display("FAIL %s frame_err: got %b want %b", name, frame_err, exp_f);
        end
        total++;
        if (data !== model_data) begin
            bad++;
            $display("FAIL %s data: got %02h want %02h", name, data, model_data);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_end: got %b want 0", name, busy);
        end
        $display("frame %s d=%02h p=%b stop=%b gap=%0d -> valid=%b perr=%b ferr=%b data=%02h",
                 name, d, p, stop_bit, gap, valid, parity_err, frame_err, data);

        if (!b2b) begin
            @(posedge clk);
            #1;
            total++;
            if ({valid, parity_err, frame_err} !== 3'b000) begin
                bad++;
                $display("FAIL %s pulse_len: got %b%b%b want 000", name, valid, parity_err, frame_err);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        sin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        sin   = 1'b1;
        model_data = '0;
        total++;
        if ({valid, parity_err, frame_err, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset flags: got %b%b%b%b want 0000", valid, parity_err, frame_err, busy);
        end
        total++;
        if (data !== 8'h00) begin
            bad++;
            $display("FAIL reset data: got %02h want 00", data);
        end
        $display("reset done: data=%02h busy=%b", data, busy);
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, "good_A5");
    endtask

    task automatic test_parity_error();
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0, "parity_3C");
    endtask

    task automatic test_frame_error();
        send_frame(8'h0F, 1'b0, 1'b0, 0, 1'b0, "frame_0F");
    endtask

    task automatic test_slow_strobe();
        send_frame(8'h81, 1'b0, 1'b1, 3, 1'b0, "slow_81");
    endtask

    task automatic test_reset_abort();
        int seen_before;
        seen_before = valid_seen;
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0);
        reset = 1'b1;
        en    = 1'b1;
        sin   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        model_data = '0;
        total++;
        if ({valid, parity_err, frame_err, busy} !== 4'b0000 || data !== 8'h00) begin
            bad++;
            $display("FAIL abort state: got v%b p%b f%b b%b d%02h want all 0",
                     valid, parity_err, frame_err, busy, data);
        end
        repeat (12) @(posedge clk);
        #1;
        total++;
        if (valid_seen != seen_before || parity_err !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL abort pulse: valid pulses got %0d want %0d", valid_seen, seen_before);
        end
        $display("abort done: busy=%b data=%02h", busy, data);
        send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0, "after_abort_55");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b0, 1'b1, 0, 1'b1, "b2b_12");
        send_frame(8'h34, 1'b0, 1'b1, 0, 1'b0, "b2b_34");
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic flip, stop_bit;
        int gap;
        bit b2b;
        for (int n = 0; n < 24; n++) begin
            d        = W'($urandom);
            flip     = ($urandom_range(0, 3) == 0);
            stop_bit = ($urandom_range(0, 3) != 0);
            gap      = $urandom_range(0, 2);
            b2b      = ($urandom_range(0, 1) == 1) && (n != 23);
            send_frame(d, flip, stop_bit, gap, b2b, "rand");
        end
    endtask

    task automatic test_totals();
        total++;
        if (valid_seen != valid_expected) begin
            bad++;
            $display("FAIL valid_count: got %0d want %0d", valid_seen, valid_expected);
        end
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL err_overlap: got %0d want 0", overlap);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        sin   = 1'b1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_frame_error();
        test_slow_strobe();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_totals();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
